iob_sync_asym_fifo_w_big: RTL and testbench



---
 rtl/iob_sync_asym_fifo_w_big_if.sv | 26 ++
 rtl/iob_sync_asym_fifo_w_big.sv | 96 +++++++++
 tb/tb_iob_sync_asym_fifo_w_big.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/iob_sync_asym_fifo_w_big_if.sv
// Handshake bundle between a wide-word producer / narrow-word consumer and the asymmetric FIFO.
// The FIFO side is the slave; the traffic side is the master.
interface iob_sync_asym_fifo_w_big_if #(
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned R_ADDR_W = 6
);
    logic                w_en;
    logic [W_DATA_W-1:0] w_data;
    logic                w_full;
    logic                r_en;
    logic [R_DATA_W-1:0] r_data;
    logic                r_valid;
    logic                r_empty;
    logic [R_ADDR_W:0]   level;

    modport master (
        output w_en, w_data, r_en,
        input  w_full, r_data, r_valid, r_empty, level
    );

    modport slave (
        input  w_en, w_data, r_en,
        output w_full, r_data, r_valid, r_empty, level
    );
endinterface

// File: rtl/iob_sync_asym_fifo_w_big.sv
// Single-clock FIFO that takes one wide word per write and drains it as RATIO narrow words,
// least-significant slice first.
module iob_sync_asym_fifo_w_big #(
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned R_ADDR_W = 6
) (
    input logic                       clk,
    input logic                       rst_n,
    iob_sync_asym_fifo_w_big_if.slave bus_if
);
    localparam int unsigned RATIO     = W_DATA_W / R_DATA_W;
    localparam int unsigned LOG2RATIO = $clog2(RATIO);
    localparam int unsigned W_ADDR_W  = R_ADDR_W - LOG2RATIO;
    localparam int unsigned DEPTH     = 2 ** R_ADDR_W;
    localparam int unsigned WPTR_W    = W_ADDR_W + 1;
    localparam int unsigned RPTR_W    = R_ADDR_W + 1;
    localparam int unsigned LVL_W     = R_ADDR_W + 1;

    // Slice addressing assumes a power-of-two ratio and at least one wide address bit.
    if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) ||
        (RATIO * R_DATA_W != W_DATA_W) || (R_ADDR_W <= LOG2RATIO)) begin : g_bad_params
        $error("iob_sync_asym_fifo_w_big: unsupported W_DATA_W/R_DATA_W/R_ADDR_W combination");
    end

    logic [R_DATA_W-1:0] mem [DEPTH];

    logic [WPTR_W-1:0]   w_ptr_q,   w_ptr_d;
    logic [RPTR_W-1:0]   r_ptr_q,   r_ptr_d;
    logic [LVL_W-1:0]    level_q,   level_d;
    logic [R_DATA_W-1:0] r_data_q,  r_data_d;
    logic                r_valid_q, r_valid_d;

    logic                r_empty;
    logic                w_full;
    logic                w_acc;
    logic                r_acc;

    // Flags come only from the registered level, so requests never reach outputs combinationally.
    assign r_empty = (level_q == '0);
    assign w_full  = (level_q > LVL_W'(DEPTH - RATIO));
    assign w_acc   = bus_if.w_en & ~w_full;
    assign r_acc   = bus_if.r_en & ~r_empty;

    always_comb begin
        w_ptr_d   = w_ptr_q;
        r_ptr_d   = r_ptr_q;
        level_d   = level_q;
        r_data_d  = r_data_q;
        r_valid_d = 1'b0;

        if (w_acc) begin
            w_ptr_d = w_ptr_q + WPTR_W'(1);
        end

        if (r_acc) begin
            r_ptr_d   = r_ptr_q + RPTR_W'(1);
            r_data_d  = mem[r_ptr_q[R_ADDR_W-1:0]];
            r_valid_d = 1'b1;
        end

        level_d = level_q + (w_acc ? LVL_W'(RATIO) : LVL_W'(0)) - (r_acc ? LVL_W'(1) : LVL_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            level_q   <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            level_q   <= level_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
        end
    end

    // Storage has no reset so it maps onto RAM; one narrow write enable per slice.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                mem[{w_ptr_q[W_ADDR_W-1:0], LOG2RATIO'(i)}] <= bus_if.w_data[i*R_DATA_W +: R_DATA_W];
            end
        end
    end

    assign bus_if.r_data  = r_data_q;
    assign bus_if.r_valid = r_valid_q;
    assign bus_if.level   = level_q;
    assign bus_if.r_empty = r_empty;
    assign bus_if.w_full  = w_full;

endmodule

// File: tb/tb_iob_sync_asym_fifo_w_big.sv
// Directed bench for the 32-to-8 asymmetric FIFO: reset, slice order, full/overflow,
// empty/underflow, simultaneous access, pointer wrap and asynchronous reset mid-stream.
module tb_iob_sync_asym_fifo_w_big;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    iob_sync_asym_fifo_w_big_if #(.W_DATA_W(32), .R_DATA_W(8), .R_ADDR_W(6)) bus_if ();

    iob_sync_asym_fifo_w_big #(.W_DATA_W(32), .R_DATA_W(8), .R_ADDR_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if.slave)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    int         exp_lvl   = 0;
    logic [7:0] exp_rdata = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given requests; acceptance follows the flags before the edge.
    task automatic do_cycle(input bit we, input logic [31:0] wd, input bit re, input string tag);
        bit w_ok;
        bit r_ok;
        w_ok = we && (exp_lvl <= 60);
        r_ok = re && (exp_lvl != 0);
        bus_if.w_en   = we;
        bus_if.w_data = wd;
        bus_if.r_en   = re;
        tick();
        bus_if.w_en = 1'b0;
        bus_if.r_en = 1'b0;
        if (r_ok) exp_rdata = exp_q.pop_front();
        if (w_ok) for (int i = 0; i < 4; i++) exp_q.push_back(wd[i*8 +: 8]);
        exp_lvl = exp_lvl + (w_ok ? 4 : 0) - (r_ok ? 1 : 0);
        check({tag, ".r_valid"}, 32'(bus_if.r_valid), 32'(r_ok));
        check({tag, ".r_data"},  32'(bus_if.r_data),  32'(exp_rdata));
        check({tag, ".level"},   32'(bus_if.level),   32'(exp_lvl));
        check({tag, ".r_empty"}, 32'(bus_if.r_empty), 32'(exp_lvl == 0));
        check({tag, ".w_full"},  32'(bus_if.w_full),  32'(exp_lvl > 60));
    endtask

    initial begin
        bus_if.w_en   = 1'b0;
        bus_if.w_data = '0;
        bus_if.r_en   = 1'b0;

        // Reset values before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst.r_empty", 32'(bus_if.r_empty), 32'd1);
        check("rst.w_full",  32'(bus_if.w_full),  32'd0);
        check("rst.level",   32'(bus_if.level),   32'd0);
        check("rst.r_data",  32'(bus_if.r_data),  32'h00);
        check("rst.r_valid", 32'(bus_if.r_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Slice order
        do_cycle(1'b1, 32'hDDCCBBAA, 1'b0, "s2.wr");
        check("s2.level4", 32'(bus_if.level), 32'd4);
        do_cycle(1'b0, 32'h0, 1'b1, "s2.rd0");
        check("s2.byte0", 32'(bus_if.r_data), 32'hAA);
        do_cycle(1'b0, 32'h0, 1'b1, "s2.rd1");
        check("s2.byte1", 32'(bus_if.r_data), 32'hBB);
        do_cycle(1'b0, 32'h0, 1'b1, "s2.rd2");
        check("s2.byte2", 32'(bus_if.r_data), 32'hCC);
        do_cycle(1'b0, 32'h0, 1'b1, "s2.rd3");
        check("s2.byte3", 32'(bus_if.r_data), 32'hDD);
        check("s2.empty", 32'(bus_if.r_empty), 32'd1);

        // Fill, overflow, drain
        for (int k = 0; k < 16; k++) do_cycle(1'b1, 32'(k), 1'b0, "s3.fill");
        check("s3.level64", 32'(bus_if.level),  32'd64);
        check("s3.full",    32'(bus_if.w_full), 32'd1);
        do_cycle(1'b1, 32'hFFFFFFFF, 1'b0, "s3.ovf");
        check("s3.ovf_level", 32'(bus_if.level), 32'd64);
        for (int j = 0; j < 64; j++) begin
            do_cycle(1'b0, 32'h0, 1'b1, "s3.drain");
            check("s3.byte", 32'(bus_if.r_data), ((j % 4) == 0) ? 32'(j / 4) : 32'h0);
        end

        // Read on empty keeps r_data
        do_cycle(1'b1, 32'h5A000000, 1'b0, "s4.wr");
        for (int j = 0; j < 4; j++) do_cycle(1'b0, 32'h0, 1'b1, "s4.rd");
        check("s4.pre", 32'(bus_if.r_data), 32'h5A);
        do_cycle(1'b0, 32'h0, 1'b1, "s4.udf");
        check("s4.hold",    32'(bus_if.r_data),  32'h5A);
        check("s4.r_valid", 32'(bus_if.r_valid), 32'd0);
        check("s4.level",   32'(bus_if.level),   32'd0);

        // Simultaneous write and read
        do_cycle(1'b1, 32'h03020100, 1'b0, "s5.wr");
        do_cycle(1'b1, 32'h07060504, 1'b0, "s5.wr");
        do_cycle(1'b1, 32'h0B0A0908, 1'b0, "s5.wr");
        do_cycle(1'b0, 32'h0, 1'b1, "s5.rd");
        do_cycle(1'b0, 32'h0, 1'b1, "s5.rd");
        check("s5.level10", 32'(bus_if.level), 32'd10);
        do_cycle(1'b1, 32'h0F0E0D0C, 1'b1, "s5.both");
        check("s5.level13", 32'(bus_if.level), 32'd13);
        for (int k = 0; k < 12; k++) do_cycle(1'b1, 32'h10101010 * 32'(k + 1), 1'b0, "s5.fill");
        check("s5.level61", 32'(bus_if.level),  32'd61);
        check("s5.full61",  32'(bus_if.w_full), 32'd1);
        do_cycle(1'b1, 32'hEEEEEEEE, 1'b1, "s5.both_full");
        check("s5.level60", 32'(bus_if.level),  32'd60);
        check("s5.nfull60", 32'(bus_if.w_full), 32'd0);
        for (int j = 0; j < 60; j++) do_cycle(1'b0, 32'h0, 1'b1, "s5.drain");

        // Continuous stream across pointer wrap
        for (int c = 0; c < 160; c++) begin
            do_cycle((c % 4) == 0, 32'h40302010 + 32'h01010101 * 32'(c / 4), 1'b1, "s6.stream");
        end
        do_cycle(1'b1, 32'hA3A2A1A0, 1'b1, "s6.both");
        for (int k = 0; k < 5; k++) do_cycle(1'b1, 32'hB0B0B0B0 + 32'(k), 1'b0, "s6.fill");
        check("s6.level24", 32'(bus_if.level), 32'd24);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("s6.rst_level",   32'(bus_if.level),   32'd0);
        check("s6.rst_empty",   32'(bus_if.r_empty), 32'd1);
        check("s6.rst_full",    32'(bus_if.w_full),  32'd0);
        check("s6.rst_r_valid", 32'(bus_if.r_valid), 32'd0);
        check("s6.rst_r_data",  32'(bus_if.r_data),  32'h00);
        exp_q.delete();
        exp_lvl   = 0;
        exp_rdata = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Normal operation after reset
        do_cycle(1'b1, 32'h44332211, 1'b0, "s7.wr");
        for (int j = 0; j < 4; j++) do_cycle(1'b0, 32'h0, 1'b1, "s7.rd");
        check("s7.last", 32'(bus_if.r_data), 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
